// File: rtl/psa_simd_acc.sv
// -----------------------------------------------------------------------------
// psa_simd_acc
// Partitioned SIMD adder/accumulator. The W = LANES*LANE_W data word is split
// into independent two's-complement lanes (lane i at bits [i*LANE_W +: LANE_W]).
// Each lane performs ADD, SUB or ACC with signed saturation. The result goes
// into a single registered output stage with a valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operation presented
//   in_ready   out  unit can accept this cycle (combinational)
//   op         in   00 ADD, 01 SUB, 10 ACC (acc+A), 11 CLR
//   A, B       in   packed lane operands (B is ignored for ACC/CLR)
//   out_valid  out  result register holds an unconsumed result
//   out_ready  in   downstream consumes the result
//   Sum        out  saturated lane-wise result
//   lane_ovfl  out  per-lane saturation flags of the current result
//   Error      out  OR of lane_ovfl (registered)
//   err_sticky out  set by any saturating accepted op, cleared by CLR/reset
// -----------------------------------------------------------------------------
module psa_simd_acc #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic [LANES*LANE_W-1:0]   A,
    input  logic [LANES*LANE_W-1:0]   B,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   Sum,
    output logic [LANES-1:0]          lane_ovfl,
    output logic                      Error,
    output logic                      err_sticky
);

    localparam int W = LANES * LANE_W;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_sum;
    logic [LANES-1:0] r_ovfl;
    logic             r_error;
    logic             r_sticky;
    logic             r_valid;

    logic [W-1:0]     w_lane_res;
    logic [LANES-1:0] w_lane_ovfl;
    logic             w_accept;

    // Ready never depends on in_valid; the output slot is free when empty or
    // being drained this cycle.
    assign in_ready = rst_n && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] w_x;
            logic [LANE_W-1:0] w_y;
            logic              w_cin;
            logic [LANE_W:0]   w_ext;
            logic              w_ov;

            // Operand steering: SUB uses A + ~B + 1, ACC adds A onto the
            // accumulator lane, CLR forces zero so the beat carries 0 / no flag.
            always_comb begin
                w_x   = '0;
                w_y   = '0;
                w_cin = 1'b0;
                case (op)
                    OP_ADD: begin
                        w_x = A[gi*LANE_W +: LANE_W];
                        w_y = B[gi*LANE_W +: LANE_W];
                    end
                    OP_SUB: begin
                        w_x   = A[gi*LANE_W +: LANE_W];
                        w_y   = ~B[gi*LANE_W +: LANE_W];
                        w_cin = 1'b1;
                    end
                    OP_ACC: begin
                        w_x = r_acc[gi*LANE_W +: LANE_W];
                        w_y = A[gi*LANE_W +: LANE_W];
                    end
                    default: begin
                        w_x = '0;
                        w_y = '0;
                    end
                endcase
            end

            // Exact result in LANE_W+1 bits; sign-extending ~B equals
            // inverting the sign-extended B, so SUB of the most-negative value
            // still yields the true difference.
            assign w_ext = {w_x[LANE_W-1], w_x} + {w_y[LANE_W-1], w_y}
                         + {{LANE_W{1'b0}}, w_cin};
            assign w_ov  = w_ext[LANE_W] ^ w_ext[LANE_W-1];

            // The top bit of the exact result gives the overflow direction.
            assign w_lane_res[gi*LANE_W +: LANE_W] =
                !w_ov          ? w_ext[LANE_W-1:0] :
                w_ext[LANE_W]  ? {1'b1, {(LANE_W-1){1'b0}}} :
                                 {1'b0, {(LANE_W-1){1'b1}}};
            assign w_lane_ovfl[gi] = w_ov;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_sum    <= '0;
            r_ovfl   <= '0;
            r_error  <= 1'b0;
            r_sticky <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum   <= w_lane_res;
                r_ovfl  <= w_lane_ovfl;
                r_error <= |w_lane_ovfl;
                r_valid <= 1'b1;
                if (op == OP_ACC) begin
                    r_acc <= w_lane_res;
                end
                if (op == OP_CLR) begin
                    r_acc    <= '0;
                    r_sticky <= 1'b0;
                end else if (|w_lane_ovfl) begin
                    r_sticky <= 1'b1;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign Sum        = r_sum;
    assign lane_ovfl  = r_ovfl;
    assign Error      = r_error;
    assign err_sticky = r_sticky;

endmodule

// File: tb/tb_psa_simd_acc.sv
module tb_psa_simd_acc;

    localparam int LW = 4;
    localparam int NL = 4;
    localparam int W  = LW * NL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  Sum;
    logic [NL-1:0] lane_ovfl;
    logic          Error;
    logic          err_sticky;

    // Second instance with 8-bit lanes, pinned only by literal checks.
    logic          p8_rst_n = 1'b0;
    logic          p8_in_valid = 1'b0;
    logic          p8_in_ready;
    logic [1:0]    p8_op = 2'b00;
    logic [15:0]   p8_A = '0;
    logic [15:0]   p8_B = '0;
    logic          p8_out_valid;
    logic [15:0]   p8_Sum;
    logic [1:0]    p8_lane_ovfl;
    logic          p8_Error;
    logic          p8_err_sticky;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    psa_simd_acc #(.LANE_W(LW), .LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .lane_ovfl(lane_ovfl), .Error(Error), .err_sticky(err_sticky)
    );

    psa_simd_acc #(.LANE_W(8), .LANES(2)) dut8 (
        .clk(clk), .rst_n(p8_rst_n), .in_valid(p8_in_valid), .in_ready(p8_in_ready),
        .op(p8_op), .A(p8_A), .B(p8_B), .out_valid(p8_out_valid), .out_ready(1'b1),
        .Sum(p8_Sum), .lane_ovfl(p8_lane_ovfl), .Error(p8_Error), .err_sticky(p8_err_sticky)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_acc = '0;
    logic [W-1:0]  m_sum = '0;
    logic [NL-1:0] m_ovfl = '0;
    logic          m_valid = 1'b0;
    logic          m_sticky = 1'b0;

    function automatic int lane_val(input logic [W-1:0] v, input int i);
        int x;
        x = int'(v[i*LW +: LW]);
        if (x >= (1 << (LW - 1))) x -= (1 << LW);
        return x;
    endfunction

    always @(posedge clk) begin
        int a, b, c, r;
        logic [W-1:0]  ns;
        logic [NL-1:0] nov;
        if (!rst_n) begin
            m_acc = '0; m_sum = '0; m_ovfl = '0; m_valid = 1'b0; m_sticky = 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            ns = '0;
            nov = '0;
            for (int i = 0; i < NL; i++) begin
                a = lane_val(A, i);
                b = lane_val(B, i);
                c = lane_val(m_acc, i);
                case (op)
                    2'b00:   r = a + b;
                    2'b01:   r = a - b;
                    2'b10:   r = c + a;
                    default: r = 0;
                endcase
                if (r > (1 << (LW - 1)) - 1) begin
                    r = (1 << (LW - 1)) - 1; nov[i] = 1'b1;
                end else if (r < -(1 << (LW - 1))) begin
                    r = -(1 << (LW - 1)); nov[i] = 1'b1;
                end
                ns[i*LW +: LW] = LW'(r);
            end
            if (op == 2'b10) m_acc = ns;
            if (op == 2'b11) begin
                m_acc = '0; m_sticky = 1'b0;
            end else if (nov != 0) begin
                m_sticky = 1'b1;
            end
            m_sum = ns; m_ovfl = nov; m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", 64'(in_ready), 64'(rst_n && (!m_valid || out_ready)));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("Sum", 64'(Sum), 64'(m_sum));
            check("lane_ovfl", 64'(lane_ovfl), 64'(m_ovfl));
            check("Error", 64'(Error), 64'(m_ovfl != 0));
            check("err_sticky", 64'(err_sticky), 64'(m_sticky));
        end
    end

    // Presents one op; in_valid is left high so consecutive calls run back-to-back.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #2;
        $display("op=%0d A=%h B=%h -> Sum=%h ovfl=%b Err=%b sticky=%b valid=%b",
                 o, a, b, Sum, lane_ovfl, Error, err_sticky, out_valid);
    endtask

    initial begin
        @(posedge clk); #2;
        cmp_en = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_Sum", 64'(Sum), 64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;

        do_op(2'b00, 16'h7321, 16'h1111);
        check("add_Sum", 64'(Sum), 64'h7432);
        check("add_ovfl", 64'(lane_ovfl), 64'h8);
        check("add_Error", 64'(Error), 64'd1);
        check("add_sticky", 64'(err_sticky), 64'd1);

        do_op(2'b01, 16'h8000, 16'h1000);
        check("sub1_Sum", 64'(Sum), 64'h8000);
        check("sub1_ovfl", 64'(lane_ovfl), 64'h8);
        do_op(2'b01, 16'h0000, 16'h8000);
        check("sub2_Sum", 64'(Sum), 64'h7000);
        check("sub2_ovfl", 64'(lane_ovfl), 64'h8);
        do_op(2'b01, 16'h5432, 16'h1111);
        check("sub3_Sum", 64'(Sum), 64'h4321);
        check("sub3_ovfl", 64'(lane_ovfl), 64'h0);
        check("sub3_sticky", 64'(err_sticky), 64'd1);

        do_op(2'b11, 16'hFFFF, 16'hFFFF);
        check("clr_Sum", 64'(Sum), 64'h0);
        check("clr_sticky", 64'(err_sticky), 64'd0);
        do_op(2'b10, 16'h3333, 16'hFFFF);
        check("acc1_Sum", 64'(Sum), 64'h3333);
        do_op(2'b10, 16'h3333, 16'h0);
        check("acc2_Sum", 64'(Sum), 64'h6666);
        check("acc2_sticky", 64'(err_sticky), 64'd0);
        do_op(2'b10, 16'h3333, 16'h0);
        check("acc3_Sum", 64'(Sum), 64'h7777);
        check("acc3_ovfl", 64'(lane_ovfl), 64'hF);
        check("acc3_sticky", 64'(err_sticky), 64'd1);
        do_op(2'b11, 16'h0, 16'h0);
        check("clr2_Sum", 64'(Sum), 64'h0);
        check("clr2_sticky", 64'(err_sticky), 64'd0);

        // Backpressure
        do_op(2'b10, 16'h1212, 16'h0);
        do_op(2'b00, 16'h1111, 16'h1111);
        check("bp_Sum", 64'(Sum), 64'h2222);
        out_ready = 1'b0;
        op = 2'b00; A = 16'h3333; B = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #2;
            check("bp_hold_Sum", 64'(Sum), 64'h2222);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #2;
        check("bp_next_Sum", 64'(Sum), 64'h3333);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        do_op(2'b10, 16'h0000, 16'h0);
        check("bp_acc_kept", 64'(Sum), 64'h1212);

        // Reset mid-stream
        do_op(2'b11, 16'h0, 16'h0);
        do_op(2'b10, 16'h3333, 16'h0);
        do_op(2'b10, 16'h3333, 16'h0);
        check("pre_rst_Sum", 64'(Sum), 64'h6666);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #2;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_Sum", 64'(Sum), 64'd0);
        check("rst_mid_ovfl", 64'(lane_ovfl), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_op(2'b10, 16'h1111, 16'h0);
        check("post_rst_acc", 64'(Sum), 64'h1111);
        in_valid = 1'b0;
        @(posedge clk); #2;
        check("drain_valid", 64'(out_valid), 64'd0);

        // 8-bit lanes
        p8_rst_n = 1'b1;
        p8_op = 2'b00; p8_A = 16'h7F80; p8_B = 16'h01FF; p8_in_valid = 1'b1;
        @(posedge clk); #2;
        p8_in_valid = 1'b0;
        $display("p8 ADD A=7f80 B=01ff -> Sum=%h ovfl=%b Err=%b", p8_Sum, p8_lane_ovfl, p8_Error);
        check("p8_Sum", 64'(p8_Sum), 64'h7F80);
        check("p8_ovfl", 64'(p8_lane_ovfl), 64'h3);
        check("p8_Error", 64'(p8_Error), 64'd1);
        check("p8_valid", 64'(p8_out_valid), 64'd1);

        @(posedge clk); #2;
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psa_simd_acc.md
# psa_simd_acc

Parametrised partitioned SIMD adder/accumulator for the CPU datapath. It splits a LANES×LANE_W word into independent signed lanes and performs lane-wise add, subtract or accumulate with per-lane signed saturation. A single registered output stage uses a valid/ready handshake, and a sticky error flag records any saturation. It serves as the next-generation packed-arithmetic unit behind the ALU's PADDSB-class instructions.

## Interface
- LANE_W, 4, bits per lane (≥2)
- LANES, 4, number of lanes (≥1); data width W = LANES*LANE_W
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept this cycle
- op  in  2  00 ADD (A+B), 01 SUB (A−B), 10 ACC (acc+A), 11 CLR
- A  in  W  operand A, lanes packed LSB-first
- B  in  W  operand B; ignored for ACC/CLR
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream consumes result
- Sum  out  W  saturated lane-wise result
- lane_ovfl  out  LANES  per-lane saturation flags for the current result
- Error  out  1  OR of lane_ovfl
- err_sticky  out  1  set by any saturating accepted op; cleared by CLR or reset

## Operation
- Accept = in_valid && in_ready. in_ready = rst_n && (!out_valid || out_ready); combinational, no dependence on in_valid.
- Lane i occupies bits [i*LANE_W +: LANE_W]; lanes are two's-complement signed; no carry crosses lanes.
- Per lane: compute exact result in LANE_W+1 bits (sign-extended operands). Overflow when the two MSBs differ. Positive overflow → 0 followed by LANE_W−1 ones (4-bit: 0x7); negative overflow → 1 followed by zeros (0x8); lane_ovfl[i]=1. Otherwise truncate to LANE_W, lane_ovfl[i]=0.
- SUB: A−B computed as A + ~B + 1 per lane; B = most-negative value saturates correctly (0 − (−8) → 0x7).
- ACC: result = sat(acc + A); acc updated to result on accept.
- CLR: acc ← 0, err_sticky ← 0; produces an output beat with Sum=0, lane_ovfl=0.
- ADD/SUB do not modify acc.
- err_sticky ← 1 on accept of any ADD/SUB/ACC with any lane_ovfl bit set; stays set until CLR or reset.
- Output register (Sum, lane_ovfl, Error) loads only on accept; holds stable while out_valid && !out_ready.
- out_valid: set on accept; cleared when out_ready && !accept; stays 1 on simultaneous consume and accept (new result replaces old, no bubble).

## Timing
- Latency 1: op accepted at edge N appears on Sum/out_valid after edge N.
- Throughput 1 op/cycle with out_ready held high.
- Reset (rst_n low at a rising edge): out_valid=0, Sum=0, lane_ovfl=0, Error=0, err_sticky=0, acc=0; in_ready=0 while rst_n low. An in-flight result is discarded; no handshake completes in a reset cycle.
- Backpressure: out_valid && !out_ready → in_ready=0; no op accepted, state frozen.
- ACC back-to-back: each accepted ACC sees acc as updated by the previous accepted ACC (no hazard bubble).
- Error is a registered function of lane_ovfl; it is never combinational from inputs.

## Test plan
- Default params, ADD A=0x7321, B=0x1111 → next cycle Sum=0x7432, lane_ovfl=4'b1000, Error=1, err_sticky=1.
- SUB A=0x8000, B=0x1000 → Sum=0x8000, lane_ovfl=4'b1000; SUB A=0x0000, B=0x8000 → Sum=0x7000, lane_ovfl=4'b1000; SUB A=0x5432, B=0x1111 → Sum=0x4321, lane_ovfl=0.
- CLR then ACC A=0x3333 ×3, out_ready=1 → Sums 0x0000, 0x3333, 0x6666, 0x7777; lane_ovfl 0, 0, 0, 4'hF; err_sticky 0 until the last beat, then 1; a further CLR → err_sticky=0, Sum=0.
- Backpressure: accept ADD 0x1111+0x1111, hold out_ready=0 for 3 cycles with in_valid=1 → Sum=0x2222 held, in_ready=0, acc unchanged; release → next op accepted in the same cycle as consumption, no gap.
- Reset mid-stream: ACC sequence leaves acc=0x6666, out_valid=1; assert rst_n=0 for 1 cycle → all outputs 0, in_ready=0 during reset; next ACC A=0x1111 → Sum=0x1111.
- LANE_W=8, LANES=2: ADD A=0x7F80, B=0x01FF → Sum=0x7F80, lane_ovfl=2'b11.
